// File: rtl/mips_decode_pipe.sv
// mips_decode_pipe: full-word MIPS decoder feeding a DEPTH-entry output FIFO.
// Optional saturating perf counters when DEC_PERF_CNT_EN is defined.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     instruction word handshake, instr = word
//   out_valid/out_ready   FIFO head handshake
//   op_onehot, illegal    decoded operation of head entry
//   rs,rt,rd,shamt,imm,   instruction fields of head entry
//   target                (all outputs read 0 while empty)
//   dec_cnt, ill_cnt      accepted / accepted-illegal word counters
module mips_decode_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned OP_W  = 36,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  op_onehot,
  output logic             illegal,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [15:0]      imm,
  output logic [25:0]      target,
  output logic [CNT_W-1:0] dec_cnt,
  output logic [CNT_W-1:0] ill_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] P_ONE = (PW+1)'(1);
  localparam logic [OP_W-1:0] OH_ONE = OP_W'(1);

  typedef struct packed {
    logic            ill;
    logic [OP_W-1:0] op;
    logic [31:0]     word;
  } ent_t;

  // ---------------- decode ----------------
  logic [5:0] opc;
  logic [5:0] fn;
  logic [4:0] rt_f;
  logic [5:0] op_idx;
  logic       op_ok;
  ent_t       ent_d;

  assign opc  = instr[31:26];
  assign fn   = instr[5:0];
  assign rt_f = instr[20:16];

  always_comb begin
    op_idx = 6'd0;
    op_ok  = 1'b1;
    unique case (opc)
      6'b000000: begin
        unique case (fn)
          6'b100110: op_idx = 6'd0;
          6'b000000: op_idx = 6'd1;
          6'b000100: op_idx = 6'd2;
          6'b000010: op_idx = 6'd3;
          6'b100010: op_idx = 6'd4;
          6'b000110: op_idx = 6'd5;
          6'b101010: op_idx = 6'd6;
          6'b001100: op_idx = 6'd7;
          6'b100011: op_idx = 6'd8;
          6'b100101: op_idx = 6'd9;
          6'b100111: op_idx = 6'd10;
          6'b100001: op_idx = 6'd11;
          6'b011000: op_idx = 6'd12;
          6'b011010: op_idx = 6'd13;
          6'b100100: op_idx = 6'd14;
          6'b100000: op_idx = 6'd15;
          6'b001000: op_idx = 6'd16;
          6'b000011: op_idx = 6'd17;
          default:   op_ok  = 1'b0;
        endcase
      end
      6'b001000: op_idx = 6'd18;
      6'b001001: op_idx = 6'd19;
      6'b001100: op_idx = 6'd20;
      6'b001110: op_idx = 6'd21;
      6'b001101: op_idx = 6'd22;
      6'b000100: op_idx = 6'd23;
      6'b000101: op_idx = 6'd24;
      6'b000110: op_idx = 6'd25;
      6'b000111: op_idx = 6'd26;
      // REGIMM: only rt=00001 (BGEZ) is in the table
      6'b000001: begin
        op_idx = 6'd27;
        op_ok  = (rt_f == 5'd1);
      end
      6'b100011: op_idx = 6'd28;
      6'b101011: op_idx = 6'd29;
      6'b100000: op_idx = 6'd30;
      6'b101000: op_idx = 6'd31;
      6'b001010: op_idx = 6'd32;
      6'b001111: op_idx = 6'd33;
      6'b000010: op_idx = 6'd34;
      6'b000011: op_idx = 6'd35;
      default:   op_ok  = 1'b0;
    endcase
  end

  always_comb begin
    ent_d      = '0;
    ent_d.ill  = !op_ok;
    ent_d.op   = op_ok ? (OH_ONE << op_idx) : '0;
    ent_d.word = instr;
  end

  // ---------------- FIFO ----------------
  ent_t        mem_q [DEPTH];
  logic [PW:0] wr_q, wr_d;
  logic [PW:0] rd_q, rd_d;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  ent_t        head;

  // extra MSB on the pointers separates full from empty
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) &&
                 (wr_q[PW-1:0] == rd_q[PW-1:0]);

  // no bypass: a full FIFO refuses even if popping this cycle
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = wr_q + P_ONE;
    if (pop)  rd_d = rd_q + P_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++)
        mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q[PW-1:0]] <= ent_d;
    end
  end

  always_comb begin
    head = '0;
    if (!empty) head = mem_q[rd_q[PW-1:0]];
  end

  assign op_onehot = head.op;
  assign illegal   = head.ill;
  assign rs        = head.word[25:21];
  assign rt        = head.word[20:16];
  assign rd        = head.word[15:11];
  assign shamt     = head.word[10:6];
  assign imm       = head.word[15:0];
  assign target    = head.word[25:0];

  // ---------------- perf counters ----------------
`ifdef DEC_PERF_CNT_EN
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] dec_q, dec_d;
  logic [CNT_W-1:0] ill_q, ill_d;

  always_comb begin
    dec_d = dec_q;
    ill_d = ill_q;
    if (push && (dec_q != '1))
      dec_d = dec_q + C_ONE;
    if (push && ent_d.ill && (ill_q != '1))
      ill_d = ill_q + C_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= '0;
      ill_q <= '0;
    end else begin
      dec_q <= dec_d;
      ill_q <= ill_d;
    end
  end

  assign dec_cnt = dec_q;
  assign ill_cnt = ill_q;
`else
  assign dec_cnt = '0;
  assign ill_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_decode_pipe.sv
// tb_mips_decode_pipe: directed + random bench for mips_decode_pipe.
// Reference: table-lookup decoder and a queue-based FIFO model.
module tb_mips_decode_pipe;

  localparam int DEPTH = 2;
  localparam int OP_W  = 36;
`ifdef DEC_PERF_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      instr = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OP_W-1:0]  op_onehot;
  logic             illegal;
  logic [4:0]       rs, rt, rd, shamt;
  logic [15:0]      imm;
  logic [25:0]      target;
  logic [CNT_W-1:0] dec_cnt, ill_cnt;

  mips_decode_pipe #(
    .DEPTH(DEPTH), .OP_W(OP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_onehot(op_onehot), .illegal(illegal),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm(imm), .target(target),
    .dec_cnt(dec_cnt), .ill_cnt(ill_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // bit index i of the one-hot vector <-> table entry i
  logic [5:0] r_fn [18] = '{
    6'h26, 6'h00, 6'h04, 6'h02, 6'h22, 6'h06, 6'h2A, 6'h0C, 6'h23,
    6'h25, 6'h27, 6'h21, 6'h18, 6'h1A, 6'h24, 6'h20, 6'h08, 6'h03};
  logic [5:0] i_op [18] = '{
    6'h08, 6'h09, 6'h0C, 6'h0E, 6'h0D, 6'h04, 6'h05, 6'h06, 6'h07,
    6'h01, 6'h23, 6'h2B, 6'h20, 6'h28, 6'h0A, 6'h0F, 6'h02, 6'h03};

  logic [31:0] q[$];
  longint      n_dec = 0;
  longint      n_ill = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_dec(input logic [31:0] w,
                                  output logic [63:0] oh,
                                  output logic il);
    int idx;
    idx = -1;
    for (int i = 0; i < 18; i++) begin
      if (w[31:26] == 6'd0 && w[5:0] == r_fn[i]) idx = i;
      if (w[31:26] != 6'd0 && w[31:26] == i_op[i]) idx = 18 + i;
    end
    if (idx == 27 && w[20:16] != 5'd1) idx = -1;
    il = (idx < 0);
    oh = il ? 64'd0 : (64'd1 << idx);
  endfunction

  function automatic longint sat(input longint n);
    longint mx;
    mx = (longint'(1) << CNT_W) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      1: begin
        w[31:26] = 6'd0;
        w[5:0]   = r_fn[$urandom_range(0, 17)];
      end
      2: w[31:26] = i_op[$urandom_range(0, 17)];
      3: begin
        w[31:26] = 6'd1;
        w[20:16] = 5'($urandom_range(0, 2));
      end
      default: ;
    endcase
    return w;
  endfunction

  task automatic check_outputs();
    logic [63:0] oh;
    logic        il;
    logic [31:0] h;
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      h = q[0];
      ref_dec(h, oh, il);
      chk("op_onehot", 64'(op_onehot), oh);
      chk("illegal", 64'(illegal), 64'(il));
      chk("rs", 64'(rs), 64'(h[25:21]));
      chk("rt", 64'(rt), 64'(h[20:16]));
      chk("rd", 64'(rd), 64'(h[15:11]));
      chk("shamt", 64'(shamt), 64'(h[10:6]));
      chk("imm", 64'(imm), 64'(h[15:0]));
      chk("target", 64'(target), 64'(h[25:0]));
    end else begin
      chk("empty_fields",
          {op_onehot[OP_W-1:0], illegal, rs, rt, rd, shamt, imm, target},
          '0);
    end
`ifdef DEC_PERF_CNT_EN
    chk("dec_cnt", 64'(dec_cnt), 64'(sat(n_dec)));
    chk("ill_cnt", 64'(ill_cnt), 64'(sat(n_ill)));
`else
    chk("dec_cnt", 64'(dec_cnt), 64'd0);
    chk("ill_cnt", 64'(ill_cnt), 64'd0);
`endif
  endtask

  // one clock: drive, check at negedge, advance model, then clock edge
  task automatic cyc(input logic v, input logic [31:0] w, input logic r);
    logic        push, pop;
    logic [63:0] oh;
    logic        il;
    logic [31:0] tmp;
    in_valid  = v;
    instr     = w;
    out_ready = r;
    @(negedge clk);
    check_outputs();
    push = v && (q.size() < DEPTH);
    pop  = r && (q.size() != 0);
    if (pop) tmp = q.pop_front();
    if (push) begin
      q.push_back(w);
      ref_dec(w, oh, il);
      n_dec++;
      if (il) n_ill++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_dec_cnt", 64'(dec_cnt), 64'd0);
    chk("rst_ill_cnt", 64'(ill_cnt), 64'd0);
    q.delete();
    n_dec = 0;
    n_ill = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 32'h0, 1'b0);

    // ADD, then ADDI vs funct-ADD aliasing, BGEZ and its illegal twin
    cyc(1'b1, 32'h00221820, 1'b1);
    cyc(1'b1, 32'h20010005, 1'b1);
    cyc(1'b1, 32'h00000020, 1'b1);
    cyc(1'b1, 32'h04210004, 1'b1);
    cyc(1'b1, 32'h04200004, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);

    // fill with out_ready low, then drain in order
    for (int i = 0; i < DEPTH + 2; i++)
      cyc(1'b1, gen_word(), 1'b0);
    for (int i = 0; i < DEPTH + 1; i++)
      cyc(1'b0, 32'h0, 1'b1);

    // full FIFO with push+pop: first cycle pops only, then steady
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, gen_word(), 1'b0);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, gen_word(), 1'b1);
    for (int i = 0; i < DEPTH + 1; i++)
      cyc(1'b0, 32'h0, 1'b1);

    // 20 accepted words, 3 illegal
    for (int i = 0; i < 20; i++) begin
      if (i == 4 || i == 9 || i == 15)
        cyc(1'b1, 32'hFC000000, 1'b1);
      else
        cyc(1'b1, {i_op[i % 18], 26'h0012345}, 1'b1);
    end
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, gen_word(), 1'b0);
    mid_reset();
    cyc(1'b0, 32'h0, 1'b0);

    // random traffic with one asynchronous flush in the middle
    for (int i = 0; i < 800; i++) begin
      if (i == 400) mid_reset();
      cyc(1'($urandom_range(0, 3) != 0), gen_word(),
          1'($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
